vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster engine, the successor to the fixed 640x480 `vga_control`. It generates horizontal and vertical sync, the active-video window and a prefetch pixel request for an external frame buffer. It also supports start/stop at frame boundaries. It sits between the frame buffer (pixel source) and the VGA connector pins, clocked by the pixel clock.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync, in lines
- `HS_POL` / `VS_POL`, 0 / 0, active level of `hs` / `vs`
- `CW`, 10, counter width; elaboration error if H_TOTAL > 2^CW or V_TOTAL > 2^CW
- `RGB_W`, 3, pixel width
- `clk_25`  in  1  pixel clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request, level-sensitive
- `pixel_in`  in  RGB_W  pixel from source, valid the cycle after `pix_req`
- `pix_req`  out  1  pixel fetch request
- `req_x` / `req_y`  out  CW  address of the requested pixel
- `hs` / `vs`  out  1  sync outputs, polarity per `HS_POL` / `VS_POL`
- `bright`  out  1  active-video window
- `h_count` / `v_count`  out  CW  raster position aligned with `bright`
- `rgb`  out  RGB_W  pixel to DAC; 0 whenever `bright` is 0
- `frame_start` / `line_start`  out  1  single-cycle pulses
- `running`  out  1  high in RUN and DRAIN states

## Operation
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is defined the same way.
- Internal counters `hc` and `vc`:
  - `hc` wraps from H_TOTAL-1 to 0 and then increments `vc`.
  - `vc` wraps from V_TOTAL-1 to 0.
- Region ordering per axis: active [0, ACTIVE), front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC), back porch.
- FSM states: STOP, RUN, DRAIN.
  - STOP to RUN when `enable`=1. Counters start at (0,0) in the next cycle.
  - RUN to DRAIN when `enable`=0.
  - DRAIN to RUN when `enable` returns to 1. The counters do not restart.
  - DRAIN to STOP on the cycle with `hc`=H_TOTAL-1 and `vc`=V_TOTAL-1, so the current frame always completes.
- In STOP:
  - counters are held at 0;
  - `hs` / `vs` are held at their inactive levels;
  - `pix_req`, `bright`, `rgb`, `frame_start` and `line_start` are all 0.
- `pix_req` is high for counter positions inside both active windows. `req_x`/`req_y` equal `hc`/`vc` when `pix_req`=1, and 0 otherwise.
- `line_start` marks `h_count`=0 on every line, including blanking lines. `frame_start` marks `h_count`=0 with `v_count`=0.
- Reset values: state STOP, counters 0, all outputs 0 except `hs`=!HS_POL and `vs`=!VS_POL.

## Timing
- Stage 1, one cycle after a counter position: `pix_req`, `req_x`, `req_y` are registered.
- Stage 2 captures `pixel_in` one cycle after `pix_req`.
- Stage 3, two cycles after `pix_req`: `rgb`, `bright`, `hs`, `vs`, `h_count`, `v_count`, `frame_start`, `line_start` are registered together and mutually aligned.
- The pixel source must return data with exactly one cycle of latency. No back-pressure is supported.
- Deasserting `enable` in the last cycle of a frame goes directly to STOP.
- Stage 2/3 pipeline contents drain normally after entering STOP (two cycles). They then settle to the STOP values.
- Asserting `reset_n` low mid-frame forces all outputs to their reset values immediately.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - adds input `pattern_sel` (1 bit);
  - when `pattern_sel`=1, `rgb` shows 8 vertical colour bars of width H_ACTIVE/8 and `pixel_in` is ignored;
  - bar index i = 0..7: R field all-ones if i[2], G field if i[1], B field if i[0];
  - requires RGB_W % 3 == 0 and H_ACTIVE % 8 == 0 (elaboration error otherwise);
  - `pix_req` still toggles as normal.
- `VGA_TEST_PATTERN_EN` not defined: the port is absent and `rgb` always comes from `pixel_in`.

## Structure
- Package `vga_pkg`: state enum (STOP/RUN/DRAIN), 640x480@60 default constants, bar colour index constants.
- Sub-module `vga_axis_counter`, instantiated once for H and once for V:
  - parameters ACTIVE/FP/SYNC/BP/CW;
  - inputs: increment enable, clear;
  - outputs: count, wrap, active, sync.

## Test plan
Test parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CW 4, polarity 0, RGB_W 3.
- Reset, then `enable`=1 -> `hs` low for exactly `h_count` 10..12 each line; `vs` low for lines 5..6; `bright` high 8 cycles per line on lines 0..3.
- Source returns `pixel_in`={req_x[1:0],req_y[0]} one cycle after `pix_req` -> `rgb` matches the formula using aligned `h_count`/`v_count` on every active pixel, and `rgb`=0 in blanking.
- Drop `enable` at `h_count`=3, `v_count`=1 -> `running` stays high until the end of line 7, then STOP. Exactly one `frame_start` is seen, with no truncated frame.
- Drop `enable` and re-raise it mid-DRAIN -> no counter discontinuity, and `frame_start` spacing stays 128 cycles.
- Pull `reset_n` low mid-line -> `hs`=`vs`=1, `bright`=0 and `rgb`=0 in the same cycle. After release with `enable`=1, the first `frame_start` appears 3 cycles after the counters start.
- With `VGA_TEST_PATTERN_EN` and `pattern_sel`=1 -> `h_count`=0..7 gives `rgb`=0,1,2..7 per single-pixel bar.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 default timing for the VGA raster engine.
package vga_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } vga_state_e;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_CW       = 10;
   localparam int VGA_RGB_W    = 3;

   // Colour bar index: bit 2 = red, bit 1 = green, bit 0 = blue.
   typedef enum logic [2:0] {
      BAR_BLACK   = 3'd0,
      BAR_BLUE    = 3'd1,
      BAR_GREEN   = 3'd2,
      BAR_CYAN    = 3'd3,
      BAR_RED     = 3'd4,
      BAR_MAGENTA = 3'd5,
      BAR_YELLOW  = 3'd6,
      BAR_WHITE   = 3'd7
   } bar_colour_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag and region decode.
// Regions in order: active [0,ACTIVE), front porch, sync, back porch.
module vga_axis_counter #(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CW     = 10
) (
   input  logic          clk_25,
   input  logic          reset_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          active,
   output logic          sync
);

   localparam int            TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

   // Position register: held at zero while cleared, wraps at the end of the axis
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= wrap ? '0 : count + 1'b1;
   end

   assign wrap   = (count == LAST);
   assign active = (int'(count) < ACTIVE);
   assign sync   = (int'(count) >= ACTIVE + FP) && (int'(count) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine with frame-boundary start/stop.
// Optional build macro VGA_TEST_PATTERN_EN adds pattern_sel and an
// internal 8-bar colour pattern that replaces pixel_in.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_STOP  | idle, counters held at 0, outputs at inactive levels
// ST_RUN   | raster running, enable high
// ST_DRAIN | enable dropped, finishing current frame before STOP
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = VGA_CW,
   parameter int RGB_W    = VGA_RGB_W
) (
   input  logic             clk_25,
   input  logic             reset_n,
   input  logic             enable,
`ifdef VGA_TEST_PATTERN_EN
   input  logic             pattern_sel,
`endif
   input  logic [RGB_W-1:0] pixel_in,
   output logic             pix_req,
   output logic [CW-1:0]    req_x,
   output logic [CW-1:0]    req_y,
   output logic             hs,
   output logic             vs,
   output logic             bright,
   output logic [CW-1:0]    h_count,
   output logic [CW-1:0]    v_count,
   output logic [RGB_W-1:0] rgb,
   output logic             frame_start,
   output logic             line_start,
   output logic             running
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > (1 << CW)) begin : g_h_width_err
      $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
   end
   if (V_TOTAL > (1 << CW)) begin : g_v_width_err
      $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
   end

   vga_state_e    state;
   logic [CW-1:0] hc, vc;
   logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
   logic          pos_valid, frame_end, req_now;

   logic          s1_valid, s1_hsync, s1_vsync;
   logic [CW-1:0] s1_hc, s1_vc;
   logic          s2_valid, s2_bright, s2_hsync, s2_vsync;
   logic [CW-1:0] s2_hc, s2_vc;
   logic [RGB_W-1:0] src_pixel;

   assign pos_valid = (state != ST_STOP);
   assign frame_end = h_wrap && v_wrap;
   assign req_now   = pos_valid && h_act && v_act;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
   ) u_h_axis (
      .clk_25(clk_25), .reset_n(reset_n),
      .inc(pos_valid), .clr(!pos_valid),
      .count(hc), .wrap(h_wrap), .active(h_act), .sync(h_sync)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
   ) u_v_axis (
      .clk_25(clk_25), .reset_n(reset_n),
      .inc(pos_valid && h_wrap), .clr(!pos_valid),
      .count(vc), .wrap(v_wrap), .active(v_act), .sync(v_sync)
   );

   // Run control: enable wins in DRAIN, otherwise stop only at the last position of a frame
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_STOP;
         running <= 1'b0;
      end else begin
         case (state)
            ST_STOP: begin
               if (enable) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  if (frame_end) begin
                     state   <= ST_STOP;
                     running <= 1'b0;
                  end else begin
                     state   <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (enable) begin
                  state <= ST_RUN;
               end else if (frame_end) begin
                  state   <= ST_STOP;
                  running <= 1'b0;
               end
            end
            default: begin
               state   <= ST_STOP;
               running <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: fetch request to the frame buffer plus raster side-band
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         pix_req  <= 1'b0;
         req_x    <= '0;
         req_y    <= '0;
         s1_valid <= 1'b0;
         s1_hsync <= 1'b0;
         s1_vsync <= 1'b0;
         s1_hc    <= '0;
         s1_vc    <= '0;
      end else begin
         pix_req  <= req_now;
         req_x    <= req_now ? hc : '0;
         req_y    <= req_now ? vc : '0;
         s1_valid <= pos_valid;
         s1_hsync <= h_sync;
         s1_vsync <= v_sync;
         s1_hc    <= hc;
         s1_vc    <= vc;
      end
   end

   // Stage 2: side-band waits here while the frame buffer answers the request
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid  <= 1'b0;
         s2_bright <= 1'b0;
         s2_hsync  <= 1'b0;
         s2_vsync  <= 1'b0;
         s2_hc     <= '0;
         s2_vc     <= '0;
      end else begin
         s2_valid  <= s1_valid;
         s2_bright <= pix_req;
         s2_hsync  <= s1_hsync;
         s2_vsync  <= s1_vsync;
         s2_hc     <= s1_hc;
         s2_vc     <= s1_vc;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int FW    = RGB_W / 3;

   if ((RGB_W % 3 != 0) || (H_ACTIVE % 8 != 0)) begin : g_pattern_err
      $error("vga_timing_gen: test pattern needs RGB_W%%3==0 and H_ACTIVE%%8==0");
   end

   bar_colour_e      bar_idx;
   logic [RGB_W-1:0] bar_rgb;

   assign bar_idx   = bar_colour_e'(3'(int'(s2_hc) / BAR_W));
   assign bar_rgb   = {{FW{bar_idx[2]}}, {FW{bar_idx[1]}}, {FW{bar_idx[0]}}};
   assign src_pixel = pattern_sel ? bar_rgb : pixel_in;
`else
   assign src_pixel = pixel_in;
`endif

   // Stage 3: all pin-facing outputs registered together so they stay aligned
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         hs          <= !HS_POL;
         vs          <= !VS_POL;
         bright      <= 1'b0;
         rgb         <= '0;
         h_count     <= '0;
         v_count     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hs          <= (s2_valid && s2_hsync) ? HS_POL : !HS_POL;
         vs          <= (s2_valid && s2_vsync) ? VS_POL : !VS_POL;
         bright      <= s2_bright;
         rgb         <= s2_bright ? src_pixel : '0;
         h_count     <= s2_hc;
         v_count     <= s2_vc;
         line_start  <= s2_valid && (s2_hc == '0);
         frame_start <= s2_valid && (s2_hc == '0) && (s2_vc == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   localparam int H_ACT = 8, H_FP = 2, H_SYN = 3, H_BP = 3, H_TOT = 16;
   localparam int V_ACT = 4, V_FP = 1, V_SYN = 2, V_BP = 1, V_TOT = 8;
   localparam int CW = 4, RGB_W = 3, FRAME = 128;
   localparam int M_STOP = 0, M_RUN = 1, M_DRAIN = 2;

   logic clk_25 = 1'b0;
   logic reset_n = 1'b1;
   logic enable = 1'b0;
   logic pattern_sel = 1'b0;
   logic [RGB_W-1:0] pixel_in = '0;
   logic pix_req, hs, vs, bright, frame_start, line_start, running;
   logic [CW-1:0] req_x, req_y, h_count, v_count;
   logic [RGB_W-1:0] rgb;

   vga_timing_gen #(
      .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
      .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .RGB_W(RGB_W)
   ) dut (
      .clk_25(clk_25), .reset_n(reset_n), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .pixel_in(pixel_in), .pix_req(pix_req), .req_x(req_x), .req_y(req_y),
      .hs(hs), .vs(vs), .bright(bright), .h_count(h_count), .v_count(v_count),
      .rgb(rgb), .frame_start(frame_start), .line_start(line_start), .running(running)
   );

   always #20 clk_25 = ~clk_25;

   typedef struct packed {
      logic hs, vs, bright, fs, ls;
      logic [3:0] hc, vc;
      logic [2:0] rgb;
   } out_t;

   typedef struct packed {
      logic req;
      logic [3:0] x, y;
   } req_t;

   typedef struct {
      int drop1;
      int rise;
      int drop2;
      int exp_run;
      int exp_fs;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   out_t exp_q[$];
   req_t exp_req = '0;
   int   m_state = M_STOP;
   int   m_hc = 0;
   int   m_vc = 0;
   logic [2:0] pend = '0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic out_t pos_rec(input int st, input int hc, input int vc, input logic psel);
      out_t r;
      logic v, br;
      logic [3:0] h4, v4;
      h4 = 4'(hc);
      v4 = 4'(vc);
      v  = (st != M_STOP);
      br = v && (hc < H_ACT) && (vc < V_ACT);
      r.hs     = !(v && hc >= H_ACT + H_FP && hc < H_ACT + H_FP + H_SYN);
      r.vs     = !(v && vc >= V_ACT + V_FP && vc < V_ACT + V_FP + V_SYN);
      r.bright = br;
      r.ls     = v && (hc == 0);
      r.fs     = v && (hc == 0) && (vc == 0);
      r.hc     = h4;
      r.vc     = v4;
      r.rgb    = br ? (psel ? h4[2:0] : {h4[1:0], v4[0]}) : 3'b000;
      return r;
   endfunction

   function automatic req_t req_rec(input int st, input int hc, input int vc);
      req_t r;
      r.req = (st != M_STOP) && (hc < H_ACT) && (vc < V_ACT);
      r.x   = r.req ? 4'(hc) : 4'd0;
      r.y   = r.req ? 4'(vc) : 4'd0;
      return r;
   endfunction

   // Reference raster model: position and run state as seen after each edge
   always @(posedge clk_25 or negedge reset_n) begin
      int nh, nv, ns;
      logic fe;
      if (!reset_n) begin
         m_state <= M_STOP;
         m_hc    <= 0;
         m_vc    <= 0;
      end else begin
         fe = (m_hc == H_TOT - 1) && (m_vc == V_TOT - 1);
         nh = m_hc;
         nv = m_vc;
         ns = m_state;
         if (m_state != M_STOP) begin
            nh = (m_hc + 1) % H_TOT;
            if (nh == 0) nv = (m_vc + 1) % V_TOT;
         end
         case (m_state)
            M_STOP:  if (enable) ns = M_RUN;
            M_RUN:   if (!enable) ns = fe ? M_STOP : M_DRAIN;
            default: if (enable) ns = M_RUN; else if (fe) ns = M_STOP;
         endcase
         m_state <= ns;
         m_hc    <= nh;
         m_vc    <= nv;
      end
   end

   // Frame buffer stand-in: answers each request with one cycle of latency
   always @(negedge clk_25) begin
      pixel_in = pend;
      pend = pix_req ? {req_x[1:0], req_y[0]} : 3'b101;
   end

   // Scoreboard: push the current position, pop the one whose outputs are due now
   always @(negedge clk_25) begin
      out_t got, exp;
      if (!reset_n) begin
         exp_q.delete();
         repeat (3) exp_q.push_back(pos_rec(M_STOP, 0, 0, 1'b0));
         exp_req = '0;
      end
      exp = exp_q.pop_front();
      got = {hs, vs, bright, frame_start, line_start, h_count, v_count, rgb};
      check("aligned outputs", 32'(got), 32'(exp));
      check("fetch request", 32'({pix_req, req_x, req_y}), 32'(exp_req));
      check("running", 32'(running), 32'(m_state != M_STOP));
      exp_q.push_back(pos_rec(m_state, m_hc, m_vc, pattern_sel));
      exp_req = req_rec(m_state, m_hc, m_vc);
   end

   task automatic wait_stopped();
      int k;
      k = 0;
      while (running && k < 600) begin
         @(negedge clk_25);
         k++;
      end
      check("stop within bound", 32'(running), 32'd0);
      repeat (4) @(negedge clk_25);
   endtask

   task automatic run_vector(input int idx, input vec_t v);
      int run_cnt, fs_cnt, first_fs, prev_fs, bad_gap, c, idle_after;
      run_cnt = 0; fs_cnt = 0; first_fs = -1; prev_fs = -1; bad_gap = 0;
      c = 0; idle_after = 0;
      @(negedge clk_25);
      enable = 1'b1;
      while (c < 1000 && idle_after < 4) begin
         @(negedge clk_25);
         if (running) run_cnt++;
         else idle_after++;
         if (frame_start) begin
            if (first_fs < 0) first_fs = c;
            else if (c - prev_fs != FRAME) bad_gap++;
            prev_fs = c;
            fs_cnt++;
         end
         if (c == v.drop1 || c == v.drop2) enable = 1'b0;
         if (c == v.rise) enable = 1'b1;
         c++;
      end
      check($sformatf("vec%0d running cycles", idx), 32'(run_cnt), 32'(v.exp_run));
      check($sformatf("vec%0d frame_start count", idx), 32'(fs_cnt), 32'(v.exp_fs));
      check($sformatf("vec%0d first frame_start", idx), 32'(first_fs), 32'd3);
      check($sformatf("vec%0d frame_start spacing", idx), 32'(bad_gap), 32'd0);
   endtask

   task automatic frame_content();
      int c, br, hsl, vsl, ls, fs;
      br = 0; hsl = 0; vsl = 0; ls = 0; fs = 0;
      @(negedge clk_25);
      enable = 1'b1;
      c = -1;
      do begin
         @(negedge clk_25);
         c++;
      end while (!frame_start && c < 20);
      check("frame_start latency", 32'(c), 32'd3);
      for (int i = 0; i < FRAME; i++) begin
         if (bright) br++;
         if (!hs) hsl++;
         if (!vs) vsl++;
         if (line_start) ls++;
         if (frame_start) fs++;
         @(negedge clk_25);
      end
      check("bright cycles per frame", 32'(br), 32'(H_ACT * V_ACT));
      check("hs low cycles per frame", 32'(hsl), 32'(H_SYN * V_TOT));
      check("vs low cycles per frame", 32'(vsl), 32'(V_SYN * H_TOT));
      check("line_start per frame", 32'(ls), 32'(V_TOT));
      check("frame_start per frame", 32'(fs), 32'd1);
      enable = 1'b0;
      wait_stopped();
   endtask

   task automatic reset_mid(input bit want_sync);
      bit found;
      int c;
      found = 1'b0;
      @(negedge clk_25);
      enable = 1'b1;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk_25);
         if (want_sync ? (!hs && !vs) : (bright && rgb != 3'b000)) found = 1'b1;
      end
      check(want_sync ? "reset trigger sync" : "reset trigger pixel", 32'(found), 32'd1);
      #5 reset_n = 1'b0;
      #1;
      check("async reset outputs",
            32'({hs, vs, bright, rgb, running, pix_req, frame_start, line_start}),
            32'({1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0}));
      @(negedge clk_25);
      @(negedge clk_25);
      reset_n = 1'b1;
      c = -1;
      do begin
         @(negedge clk_25);
         c++;
      end while (!frame_start && c < 20);
      check("frame_start after reset", 32'(c), 32'd3);
      enable = 1'b0;
      wait_stopped();
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{22,  -1,  -1, 128, 1};
      vecs[1] = '{127, -1,  -1, 128, 1};
      vecs[2] = '{128, -1,  -1, 256, 2};
      vecs[3] = '{40,  60,  200, 256, 2};
      vecs[4] = '{0,   -1,  -1, 128, 1};
      vecs[5] = '{126, 127, 300, 384, 3};

      #1 reset_n = 1'b0;
      #2;
      check("reset idle outputs",
            32'({hs, vs, bright, rgb, running, pix_req, frame_start, line_start, h_count, v_count}),
            32'({1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}));
      repeat (3) @(negedge clk_25);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_25);

      frame_content();
      for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);
      reset_mid(1'b0);
      reset_mid(1'b1);

`ifdef VGA_TEST_PATTERN_EN
      begin
         int c;
         pattern_sel = 1'b1;
         @(negedge clk_25);
         enable = 1'b1;
         c = 0;
         do begin
            @(negedge clk_25);
            c++;
         end while (!frame_start && c < 20);
         for (int i = 0; i < H_ACT; i++) begin
            check($sformatf("bar %0d", i), 32'(rgb), 32'(i));
            @(negedge clk_25);
         end
         enable = 1'b0;
         wait_stopped();
         pattern_sel = 1'b0;
      end
`endif

      repeat (5) @(negedge clk_25);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
